// File: rtl/blockram_arbiter.sv
// blockram_arbiter: round-robin arbiter with optional burst lock that shares one single-port BlockRAM
// between two requesters. Each port gets a registered read-data path that holds its last result.
module blockram_arbiter #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [AddrWidth-1:0] a_addr,
  input  logic [DataWidth-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DataWidth-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [AddrWidth-1:0] b_addr,
  input  logic [DataWidth-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DataWidth-1:0] b_rdata,
  output logic [AddrWidth-1:0] ram_addr,
  output logic [DataWidth-1:0] ram_wdata,
  output logic                 ram_we,
  input  logic [DataWidth-1:0] ram_data
);
  typedef enum logic [1:0] {PRIO_A, PRIO_B, LOCK_A, LOCK_B} state_t;
  state_t state;
  logic [AddrWidth-1:0] addr_q;
  logic [1:0] pend1, pend2;
  always_comb begin
    a_gnt = rst_n & a_req & ((state == PRIO_A) | (state == LOCK_A) | ((state == PRIO_B) & ~b_req));
    b_gnt = rst_n & b_req & ((state == PRIO_B) | (state == LOCK_B) | ((state == PRIO_A) & ~a_req));
    ram_addr = a_gnt ? a_addr : b_gnt ? b_addr : addr_q;
    ram_wdata = b_gnt ? b_wdata : a_wdata;
    ram_we = (a_gnt & a_we) | (b_gnt & b_we);
  end
  // pend1/pend2 carry {b,a} read tags through the RAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRIO_A;
      addr_q <= '0;
      pend1 <= '0;
      pend2 <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      addr_q <= ram_addr;
      pend1 <= {b_gnt & ~b_we, a_gnt & ~a_we};
      pend2 <= pend1;
      if (pend1[0]) a_rdata <= ram_data;
      if (pend1[1]) b_rdata <= ram_data;
      if (a_gnt) state <= a_lock ? LOCK_A : PRIO_B;
      else if (b_gnt) state <= b_lock ? LOCK_B : PRIO_A;
      else if ((state == LOCK_A) && !a_req) state <= PRIO_B;
      else if ((state == LOCK_B) && !b_req) state <= PRIO_A;
    end
  end
  assign a_rvalid = pend2[0];
  assign b_rvalid = pend2[1];
endmodule

// File: tb/tb_blockram_arbiter.sv
// tb_blockram_arbiter: directed and random checks of blockram_arbiter against a priority/owner
// reference model with its own memory image and a due-cycle queue of read results.
module tb_blockram_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  logic clk = 0;
  logic rst_n = 1;
  logic [1:0] req, we, lock;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] lat;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] ref_mem [2**AW];
  int prio, owner;
  logic [AW-1:0] last_addr, ea;
  logic [1:0] eg, erv;
  logic [DW-1:0] exp_rd [2];
  typedef struct {int due; int port; logic [DW-1:0] data;} rd_t;
  rd_t rq[$];

  blockram_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(req[0]), .a_we(we[0]), .a_lock(lock[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(req[1]), .b_we(we[1]), .b_lock(lock[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // BlockRAM model: registered address, write at the edge, combinational data out
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    lat <= ram_addr;
  end
  assign ram_data = mem[lat];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_gnt(int p);
    if (!rst_n) return 1'b0;
    if (owner >= 0) return (owner == p) && req[p];
    return req[p] && (prio == p || !req[1-p]);
  endfunction

  task automatic reset_model();
    rq.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    prio = 0;
    owner = -1;
    last_addr = '0;
    eg = '0;
  endtask

  task automatic check();
    eg[0] = exp_gnt(0);
    eg[1] = exp_gnt(1);
    ea = eg[0] ? addr[0] : eg[1] ? addr[1] : last_addr;
    erv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv[rq[0].port] = 1'b1;
      exp_rd[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("a_gnt", 32'(a_gnt), 32'(eg[0]));
    chk("b_gnt", 32'(b_gnt), 32'(eg[1]));
    chk("both_gnt", 32'(a_gnt & b_gnt), 32'(0));
    chk("ram_we", 32'(ram_we), 32'((eg[0] & we[0]) | (eg[1] & we[1])));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    if (ram_we === 1'b1) chk("ram_wdata", 32'(ram_wdata), 32'(eg[0] ? wdata[0] : wdata[1]));
    chk("a_rvalid", 32'(a_rvalid), 32'(erv[0]));
    chk("b_rvalid", 32'(b_rvalid), 32'(erv[1]));
    chk("a_rdata", 32'(a_rdata), 32'(exp_rd[0]));
    chk("b_rdata", 32'(b_rdata), 32'(exp_rd[1]));
  endtask

  task automatic commit();
    if (!rst_n) reset_model();
    else begin
      for (int p = 0; p < 2; p++) if (eg[p]) begin
        if (we[p]) ref_mem[addr[p]] = wdata[p];
        else rq.push_back('{cyc + 2, p, ref_mem[addr[p]]});
        if (lock[p]) owner = p;
        else begin
          owner = -1;
          prio = 1 - p;
        end
      end
      if (eg == 2'b00 && owner >= 0 && !req[owner]) begin
        prio = 1 - owner;
        owner = -1;
      end
      if (eg != 2'b00) last_addr = ea;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drv(int p, logic r, logic w, logic l, int ad, int wd);
    req[p] = r;
    we[p] = w;
    lock[p] = l;
    addr[p] = AW'(ad);
    wdata[p] = DW'(wd);
  endtask

  task automatic do_reset();
    rst_n = 0;
    reset_model();
    repeat (2) tick();
    rst_n = 1;
  endtask

  initial begin
    req = '0;
    we = '0;
    lock = '0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0;
      wdata[p] = '0;
    end
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[1] = 8'h11;
    ref_mem[1] = 8'h11;
    mem[2] = 8'h22;
    ref_mem[2] = 8'h22;
    reset_model();
    #1;
    do_reset();
    // write then read back on A
    drv(0, 1, 1, 0, 'h10, 'h5A); tick();
    drv(0, 1, 0, 0, 'h10, 0); tick();
    drv(0, 0, 0, 0, 0, 0); tick(); tick();
    chk("t1_a_rdata", 32'(a_rdata), 32'h5A);
    // contested reads alternate starting with A
    do_reset();
    drv(0, 1, 0, 0, 'h01, 0);
    drv(1, 1, 0, 0, 'h02, 0);
    repeat (6) tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("t2_a_rdata", 32'(a_rdata), 32'h11);
    chk("t2_b_rdata", 32'(b_rdata), 32'h22);
    // B locked burst of writes while A waits
    drv(1, 1, 1, 1, 'h20, 'hA0); tick();
    drv(0, 1, 0, 0, 'h23, 0);
    for (int i = 1; i < 4; i++) begin
      drv(1, 1, 1, 1, 'h20 + i, 'hA0 + i);
      tick();
    end
    drv(1, 0, 0, 0, 0, 0); tick(); tick();
    drv(0, 0, 0, 0, 0, 0); tick(); tick();
    chk("t3_a_rdata", 32'(a_rdata), 32'hA3);
    // write by A, immediate read of same address by B
    drv(0, 1, 1, 0, 'h30, 'h77); tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 'h30, 0); tick();
    drv(1, 0, 0, 0, 0, 0); tick(); tick();
    chk("t4_b_rdata", 32'(b_rdata), 32'h77);
    // reset while a read is in flight
    drv(0, 1, 0, 0, 'h10, 0); tick();
    drv(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    reset_model();
    tick(); tick();
    chk("t5_a_rdata", 32'(a_rdata), 32'h0);
    rst_n = 1;
    drv(0, 1, 0, 0, 'h01, 0);
    drv(1, 1, 0, 0, 'h02, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    // idle stretch
    repeat (10) tick();
    // random traffic; a requester holds its request until granted
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < 2; p++) if (!(req[p] && !eg[p])) begin
        req[p] = $urandom_range(0, 3) != 0;
        we[p] = 1'($urandom_range(0, 1));
        lock[p] = $urandom_range(0, 5) == 0;
        addr[p] = AW'($urandom_range(0, 15));
        wdata[p] = DW'($urandom);
      end
      if (k == 1500) begin
        rst_n = 0;
        reset_model();
        tick();
        rst_n = 1;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
